// File: rtl/argmax_classifier.sv
// argmax_classifier: final stage of the MNIST inference pipeline.
// Streams one frame of NUM_CLASSES signed scores, one per input transfer, and
// presents the index and value of the largest score on a valid/ready output.
// Ties keep the lowest index. frame_count tallies delivered results.
module argmax_classifier #(
   parameter int NUM_CLASSES = 10,
   parameter int IDX_W       = 4,
   parameter int CNT_W       = 16,
   parameter int FEAT_W      = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              features_in_valid,
   output logic              features_in_ready,
   input  logic [FEAT_W-1:0] features_in_features,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [IDX_W-1:0]  result_class,
   output logic [FEAT_W-1:0] result_score,
   output logic [CNT_W-1:0]  frame_count
);

   typedef enum logic {
      S_RECV,
      S_HOLD
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   elem_idx;
   logic [IDX_W-1:0]   best_idx;
   logic [FEAT_W-1:0]  best_score;
   logic [IDX_W-1:0]   cand_idx;
   logic [FEAT_W-1:0]  cand_score;
   logic               in_xfer;
   logic               out_xfer;
   logic               last_elem;

   assign last_elem = (elem_idx == IDX_W'(NUM_CLASSES - 1));

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_RECV;
      end else begin
         state <= state_next;
      end
   end

   // Next state, handshake decode and running-best candidate (including the
   // element being accepted this cycle).
   always_comb begin
      state_next        = state;
      features_in_ready = 1'b0;
      in_xfer           = 1'b0;
      out_xfer          = 1'b0;
      cand_idx          = best_idx;
      cand_score        = best_score;
      unique case (state)
         S_RECV: begin
            features_in_ready = 1'b1;
            in_xfer           = features_in_valid;
            if (in_xfer) begin
               if ((elem_idx == '0) ||
                   ($signed(features_in_features) > $signed(best_score))) begin
                  cand_idx   = elem_idx;
                  cand_score = features_in_features;
               end
               if (last_elem) begin
                  state_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            out_xfer = result_ready;
            if (out_xfer) begin
               state_next = S_RECV;
            end
         end
         default: begin
            state_next = S_RECV;
         end
      endcase
   end

   // Datapath: running best, element counter, result registers, frame count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         elem_idx     <= '0;
         best_idx     <= '0;
         best_score   <= '0;
         result_valid <= 1'b0;
         result_class <= '0;
         result_score <= '0;
         frame_count  <= '0;
      end else begin
         if (in_xfer) begin
            best_idx   <= cand_idx;
            best_score <= cand_score;
            if (last_elem) begin
               elem_idx     <= '0;
               result_class <= cand_idx;
               result_score <= cand_score;
               result_valid <= 1'b1;
            end else begin
               elem_idx <= elem_idx + IDX_W'(1);
            end
         end
         if (out_xfer) begin
            result_valid <= 1'b0;
            frame_count  <= frame_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed and randomized frames
// compared against a loop-based argmax reference model.
module tb_argmax_classifier;

   localparam int NC = 10;
   localparam int IW = 4;
   localparam int CW = 4;
   localparam int FW = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          features_in_valid;
   logic          features_in_ready;
   logic [FW-1:0] features_in_features;
   logic          result_valid;
   logic          result_ready;
   logic [IW-1:0] result_class;
   logic [FW-1:0] result_score;
   logic [CW-1:0] frame_count;

   int tests     = 0;
   int failed    = 0;
   int exp_count = 0;
   int cyc       = 0;
   logic signed [FW-1:0] frame [NC];

   argmax_classifier #(
      .NUM_CLASSES (NC),
      .IDX_W       (IW),
      .CNT_W       (CW),
      .FEAT_W      (FW)
   ) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .features_in_valid    (features_in_valid),
      .features_in_ready    (features_in_ready),
      .features_in_features (features_in_features),
      .result_valid         (result_valid),
      .result_ready         (result_ready),
      .result_class         (result_class),
      .result_score         (result_score),
      .frame_count          (frame_count)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Cycle counter used to measure frame period.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: first maximum over the frame, signed comparison.
   function automatic void ref_argmax(output int bi, output logic [FW-1:0] bs);
      logic signed [FW-1:0] best;
      bi   = 0;
      best = frame[0];
      for (int i = 1; i < NC; i++) begin
         if (frame[i] > best) begin
            bi   = i;
            best = frame[i];
         end
      end
      bs = best;
   endfunction

   task automatic fill(input int base, input int idx_a, input int val_a,
                       input int idx_b, input int val_b);
      for (int i = 0; i < NC; i++) frame[i] = FW'(base);
      if (idx_a >= 0) frame[idx_a] = FW'(val_a);
      if (idx_b >= 0) frame[idx_b] = FW'(val_b);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NC; i++) frame[i] = FW'(int'($urandom_range(0, 40)) - 20);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rvalid"}, 32'(result_valid), 0);
      check({tag, "_rclass"}, 32'(result_class), 0);
      check({tag, "_rscore"}, 32'(result_score), 0);
      check({tag, "_fcount"}, 32'(frame_count), 0);
      check({tag, "_ready"},  32'(features_in_ready), 1);
   endtask

   task automatic do_reset();
      features_in_valid    = 1'b0;
      features_in_features = '0;
      result_ready         = 1'b0;
      reset_n              = 1'b0;
      #1;
      check_reset_values("reset");
      @(negedge clock);
      reset_n   = 1'b1;
      exp_count = 0;
      @(negedge clock);
   endtask

   // Send the current frame with random input gaps up to max_gap cycles.
   task automatic send_frame(input int max_gap);
      int            g;
      int            bi;
      logic [FW-1:0] bs;
      for (int i = 0; i < NC; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (g) begin
            features_in_valid    = 1'b0;
            features_in_features = FW'($urandom);
            @(negedge clock);
         end
         features_in_valid    = 1'b1;
         features_in_features = frame[i];
         check("in_ready", 32'(features_in_ready), 1);
         if (i == NC - 1) check("valid_before_last", 32'(result_valid), 0);
         @(negedge clock);
      end
      features_in_valid = 1'b0;
      ref_argmax(bi, bs);
      check("valid_after_last", 32'(result_valid), 1);
      check("class", 32'(result_class), 32'(bi));
      check("score", 32'(result_score), 32'(bs));
   endtask

   // Hold result_ready low for hold cycles while upstream offers junk, then handshake.
   task automatic take_result(input int hold);
      int            bi;
      logic [FW-1:0] bs;
      ref_argmax(bi, bs);
      repeat (hold) begin
         features_in_valid    = 1'b1;
         features_in_features = FW'($urandom);
         @(negedge clock);
         check("hold_ready", 32'(features_in_ready), 0);
         check("hold_valid", 32'(result_valid), 1);
         check("hold_class", 32'(result_class), 32'(bi));
         check("hold_score", 32'(result_score), 32'(bs));
      end
      features_in_valid    = 1'b1;
      features_in_features = FW'($urandom);
      result_ready         = 1'b1;
      @(negedge clock);
      result_ready      = 1'b0;
      features_in_valid = 1'b0;
      exp_count         = (exp_count + 1) % (1 << CW);
      check("post_hs_valid", 32'(result_valid), 0);
      check("post_hs_count", 32'(frame_count), 32'(exp_count));
      check("post_hs_ready", 32'(features_in_ready), 1);
   endtask

   initial begin
      int            bi;
      int            start;
      logic [FW-1:0] bs;

      reset_n              = 1'b0;
      features_in_valid    = 1'b0;
      features_in_features = '0;
      result_ready         = 1'b0;
      @(negedge clock);
      do_reset();

      // Single clear maximum.
      fill(5, 7, 100, -1, 0);
      send_frame(0);
      check("t1_class", 32'(result_class), 7);
      check("t1_score", 32'(result_score), 100);
      take_result(0);
      check("t1_count", 32'(frame_count), 1);

      // Ties keep lowest index.
      fill(1, 2, 50, 8, 50);
      send_frame(0);
      check("t2_tie_class", 32'(result_class), 2);
      take_result(0);
      fill(33, -1, 0, -1, 0);
      send_frame(0);
      check("t2_equal_class", 32'(result_class), 0);
      take_result(0);

      // All-negative scores.
      fill(-20, 4, -3, -1, 0);
      send_frame(0);
      check("t3_class", 32'(result_class), 4);
      check("t3_score", 32'(result_score), 32'(16'hFFFD));
      take_result(0);

      // Random gaps on input, long output back-pressure.
      for (int f = 0; f < 3; f++) begin
         fill_random();
         send_frame(3);
         take_result(20);
      end

      // Reset part-way through a frame discards the partial frame.
      for (int i = 0; i < 6; i++) begin
         features_in_valid    = 1'b1;
         features_in_features = (i == 0) ? FW'(1000) : FW'(2);
         @(negedge clock);
      end
      do_reset();
      fill(10, 1, 90, -1, 0);
      send_frame(0);
      check("t5_class", 32'(result_class), 1);
      take_result(0);
      check("t5_count", 32'(frame_count), 1);

      // Back-to-back frames with result_ready pre-asserted; counter wraps.
      do_reset();
      result_ready = 1'b1;
      for (int f = 0; f < (1 << CW) + 1; f++) begin
         fill_random();
         start = cyc;
         for (int i = 0; i < NC; i++) begin
            features_in_valid    = 1'b1;
            features_in_features = frame[i];
            check("b2b_ready", 32'(features_in_ready), 1);
            @(negedge clock);
         end
         ref_argmax(bi, bs);
         check("b2b_valid", 32'(result_valid), 1);
         check("b2b_class", 32'(result_class), 32'(bi));
         check("b2b_score", 32'(result_score), 32'(bs));
         check("b2b_hold_ready", 32'(features_in_ready), 0);
         features_in_features = FW'($urandom);
         @(negedge clock);
         exp_count = (exp_count + 1) % (1 << CW);
         check("b2b_valid_low", 32'(result_valid), 0);
         check("b2b_count", 32'(frame_count), 32'(exp_count));
         check("b2b_period", 32'(cyc - start), 11);
      end
      features_in_valid = 1'b0;
      result_ready      = 1'b0;
      check("wrap_count", 32'(frame_count), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
